// File: rtl/dt_vote_pkg.sv
// -----------------------------------------------------------------------------
// dt_vote_pkg
// Shared definitions for the decision-tree vote filter:
//   NUM_CLASSES     width of the one-hot decision vector
//   class_idx_t     3-bit class index
//   fill_state_e    window occupancy FSM states
//   is_onehot       true iff exactly one bit of a decision vector is set
//   onehot_to_index index of the lowest set bit of a decision vector
// -----------------------------------------------------------------------------
package dt_vote_pkg;

  localparam int NUM_CLASSES = 5;
  localparam int CLASS_W     = 3;

  typedef logic [CLASS_W-1:0] class_idx_t;

  // EMPTY: no samples, FILLING: 0 < fill < WIN, FULL: fill == WIN.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [NUM_CLASSES-1:0] d);
    logic [NUM_CLASSES-1:0] d_minus_1;
    d_minus_1 = d - NUM_CLASSES'(1);
    return (d != '0) && ((d & d_minus_1) == '0);
  endfunction

  // Scans from the top down so the lowest set bit wins; only meaningful
  // when the vector is one-hot.
  function automatic class_idx_t onehot_to_index(input logic [NUM_CLASSES-1:0] d);
    class_idx_t idx;
    idx = '0;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (d[i]) idx = class_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dt_vote_filter_if.sv
// -----------------------------------------------------------------------------
// dt_vote_filter_if
// Groups the two valid/ready streams of the vote filter:
//   input stream : in_valid, in_ready, in_decision (one-hot class vector)
//   output stream: out_valid, out_ready, out_class, out_onehot, out_votes,
//                  out_conf
// Modports:
//   master - the environment: classifier side producer and host side consumer
//   slave  - the filter itself
// -----------------------------------------------------------------------------
interface dt_vote_filter_if
  import dt_vote_pkg::*;
#(
  parameter int N_CLS = NUM_CLASSES,
  parameter int CNT_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [N_CLS-1:0]  in_decision;

  logic              out_valid;
  logic              out_ready;
  class_idx_t        out_class;
  logic [N_CLS-1:0]  out_onehot;
  logic [CNT_W-1:0]  out_votes;
  logic              out_conf;

  modport master (
    output in_valid, in_decision, out_ready,
    input  in_ready, out_valid, out_class, out_onehot, out_votes, out_conf
  );

  modport slave (
    input  in_valid, in_decision, out_ready,
    output in_ready, out_valid, out_class, out_onehot, out_votes, out_conf
  );

endinterface

// File: rtl/dt_vote_argmax.sv
// -----------------------------------------------------------------------------
// dt_vote_argmax
// Combinational argmax over NUM_CLASSES vote counts. Ties resolve to the
// lowest class index.
// Ports:
//   counts   in   packed per-class vote counts, class 0 in the low slot
//   win_idx  out  index of the winning class
//   win_cnt  out  vote count of the winning class
// -----------------------------------------------------------------------------
module dt_vote_argmax
  import dt_vote_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [NUM_CLASSES-1:0][CNT_W-1:0] counts,
  output class_idx_t                        win_idx,
  output logic [CNT_W-1:0]                  win_cnt
);

  // Strict '>' keeps the earlier (lower) index on equal counts.
  always_comb begin
    win_idx = '0;
    win_cnt = counts[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (counts[i] > win_cnt) begin
        win_idx = class_idx_t'(i);
        win_cnt = counts[i];
      end
    end
  end

endmodule

// File: rtl/dt_vote_filter.sv
// -----------------------------------------------------------------------------
// dt_vote_filter
// Majority-vote smoother for the one-hot decisions of the decision-tree
// classifier. Keeps the last WIN valid decisions in a ring, tracks per-class
// vote counts, and publishes the winning class one cycle after each accepted
// valid decision. Non-one-hot decisions are dropped and counted.
// Ports:
//   CLK        in   clock, all state on the rising edge
//   RST        in   synchronous active-high reset (priority over clear)
//   clear      in   synchronous window flush; holds in_ready low
//   bus        slave modport: decision input stream and result output stream
//   fill       out  samples currently in the window (0..WIN)
//   err_count  out  saturating count of rejected (non-one-hot) decisions
// -----------------------------------------------------------------------------
module dt_vote_filter
  import dt_vote_pkg::*;
#(
  parameter int WIN   = 8,
  parameter int CNT_W = 5,
  parameter int ERR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  dt_vote_filter_if.slave   bus,
  output logic [CNT_W-1:0]  fill,
  output logic [ERR_W-1:0]  err_count
);

  localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;

  typedef logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_vec_t;

  // Window state
  cnt_vec_t          cnt_q,   cnt_d;
  logic [CNT_W-1:0]  fill_q,  fill_d;
  logic [PTR_W-1:0]  wptr_q,  wptr_d;
  fill_state_e       state_q, state_d;
  class_idx_t        ring_q [WIN];
  logic              ring_we;

  // Output register
  logic                   out_valid_q,  out_valid_d;
  class_idx_t             out_class_q,  out_class_d;
  logic [NUM_CLASSES-1:0] out_onehot_q, out_onehot_d;
  logic [CNT_W-1:0]       out_votes_q,  out_votes_d;
  logic                   out_conf_q,   out_conf_d;

  logic [ERR_W-1:0]  err_q, err_d;

  // Per-cycle decode
  logic              in_ready;
  logic              accept;
  logic              sample_ok;
  logic              take;
  logic              reject;
  logic              evict;
  class_idx_t        in_cls;
  class_idx_t        evict_cls;
  class_idx_t        win_idx;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W:0]    twice_votes;

  // ---------------------------------------------------------------------------
  // Handshake and sample decode
  // ---------------------------------------------------------------------------
  // A new sample is only taken when the output slot is free or being drained
  // this cycle, and never during a flush.
  assign in_ready  = !clear && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign sample_ok = is_onehot(bus.in_decision);
  assign take      = accept && sample_ok;
  assign reject    = accept && !sample_ok;
  assign in_cls    = onehot_to_index(bus.in_decision);

  // Only a full window evicts; the oldest entry sits where the next write goes.
  assign evict     = take && (state_q == FULL);
  assign evict_cls = ring_q[wptr_q];

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next-state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (take) state_d = FILLING;
      FILLING: if (take && (fill_q == CNT_W'(WIN - 1))) state_d = FULL;
      FULL:    state_d = FULL;
      default: state_d = EMPTY;
    endcase
    if (clear) state_d = EMPTY;
  end

  // ---------------------------------------------------------------------------
  // Vote counters, fill and ring pointer
  // ---------------------------------------------------------------------------
  // NOTE: blocking assignments inside always_comb are evaluated in order, so
  // when the evicted class equals the incoming one the +1 and -1 cancel.
  always_comb begin
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    wptr_d  = wptr_q;
    ring_we = 1'b0;
    if (take) begin
      cnt_d[in_cls] = cnt_d[in_cls] + CNT_W'(1);
      if (evict) cnt_d[evict_cls] = cnt_d[evict_cls] - CNT_W'(1);
      else       fill_d = fill_q + CNT_W'(1);
      wptr_d  = (wptr_q == PTR_W'(WIN - 1)) ? '0 : wptr_q + PTR_W'(1);
      ring_we = 1'b1;
    end
    if (clear) begin
      cnt_d   = '0;
      fill_d  = '0;
      wptr_d  = '0;
      ring_we = 1'b0;
    end
  end

  // Argmax runs on the post-update counts so the result reflects this sample.
  dt_vote_argmax #(
    .CNT_W (CNT_W)
  ) u_argmax (
    .counts  (cnt_d),
    .win_idx (win_idx),
    .win_cnt (win_cnt)
  );

  // Strict majority against the post-update fill: 2*votes > fill.
  assign twice_votes = {win_cnt, 1'b0};

  // ---------------------------------------------------------------------------
  // Output register and error counter
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_onehot_d = out_onehot_q;
    out_votes_d  = out_votes_q;
    out_conf_d   = out_conf_q;
    err_d        = err_q;

    if (take) begin
      out_valid_d  = 1'b1;
      out_class_d  = win_idx;
      out_onehot_d = NUM_CLASSES'(1) << win_idx;
      out_votes_d  = win_cnt;
      out_conf_d   = twice_votes > {1'b0, fill_d};
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // A flush discards any result the host has not taken yet.
    if (clear) out_valid_d = 1'b0;

    if (reject && (err_q != '1)) err_d = err_q + ERR_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      fill_q       <= '0;
      wptr_q       <= '0;
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_onehot_q <= '0;
      out_votes_q  <= '0;
      out_conf_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      wptr_q       <= wptr_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_onehot_q <= out_onehot_d;
      out_votes_q  <= out_votes_d;
      out_conf_q   <= out_conf_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the ring has no reset; an entry is only read for eviction once the
  // FSM is FULL, by which point every slot has been written since the last
  // reset or flush.
  always_ff @(posedge CLK) begin
    if (ring_we) ring_q[wptr_q] <= in_cls;
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_class  = out_class_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.out_votes  = out_votes_q;
  assign bus.out_conf   = out_conf_q;
  assign fill           = fill_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_dt_vote_filter.sv
// -----------------------------------------------------------------------------
// tb_dt_vote_filter
// Directed bench for dt_vote_filter (WIN=8, CNT_W=5, ERR_W=4 so that error
// saturation is reachable in a few cycles). A table of {reset-before,
// decision, expected result} records drives the streaming cases; hand-written
// sequences cover invalid inputs, saturation, backpressure and clear.
// -----------------------------------------------------------------------------
module tb_dt_vote_filter;
  import dt_vote_pkg::*;

  localparam int WIN   = 8;
  localparam int CNT_W = 5;
  localparam int ERR_W = 4;

  logic              CLK;
  logic              RST;
  logic              clear;
  logic [CNT_W-1:0]  fill;
  logic [ERR_W-1:0]  err_count;

  int n_checks;
  int n_errors;

  dt_vote_filter_if #(.N_CLS(NUM_CLASSES), .CNT_W(CNT_W)) bus ();

  dt_vote_filter #(
    .WIN   (WIN),
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .bus       (bus),
    .fill      (fill),
    .err_count (err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit                     rst_before;
    logic [NUM_CLASSES-1:0] dec;
    int                     cls;
    int                     votes;
    int                     conf;
    int                     fill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST             = 1'b1;
    clear           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_decision = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Presents one decision, waits (bounded) for in_ready, and returns #1 after
  // the accepting edge with in_valid dropped again.
  task automatic send_sample(input logic [NUM_CLASSES-1:0] d);
    int budget;
    @(negedge CLK);
    bus.in_valid    = 1'b1;
    bus.in_decision = d;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cls, input int votes,
                              input int conf, input int fl);
    check({tag, ".out_valid"},  int'(bus.out_valid),  1);
    check({tag, ".out_class"},  int'(bus.out_class),  cls);
    check({tag, ".out_onehot"}, int'(bus.out_onehot), 1 << cls);
    check({tag, ".out_votes"},  int'(bus.out_votes),  votes);
    check({tag, ".out_conf"},   int'(bus.out_conf),   conf);
    check({tag, ".fill"},       int'(fill),           fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST             = 1'b1;
    clear           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_decision = '0;
    bus.out_ready   = 1'b1;

    // --- stream table ----------------------------------------------------
    // Three samples of class 2.
    vecs.push_back('{1'b0, 5'b00100, 2, 1, 1, 1});
    vecs.push_back('{1'b0, 5'b00100, 2, 2, 1, 2});
    vecs.push_back('{1'b0, 5'b00100, 2, 3, 1, 3});
    // Classes 0,0,0,1,1,1,1,1 fill the window; then evictions.
    vecs.push_back('{1'b1, 5'b00001, 0, 1, 1, 1});
    vecs.push_back('{1'b0, 5'b00001, 0, 2, 1, 2});
    vecs.push_back('{1'b0, 5'b00001, 0, 3, 1, 3});
    vecs.push_back('{1'b0, 5'b00010, 0, 3, 1, 4});
    vecs.push_back('{1'b0, 5'b00010, 0, 3, 1, 5});
    vecs.push_back('{1'b0, 5'b00010, 0, 3, 0, 6});  // 3:3 tie -> class 0, 6 !> 6
    vecs.push_back('{1'b0, 5'b00010, 1, 4, 1, 7});
    vecs.push_back('{1'b0, 5'b00010, 1, 5, 1, 8});
    vecs.push_back('{1'b0, 5'b00100, 1, 5, 1, 8});  // evicts a 0 -> {2,5,1}
    vecs.push_back('{1'b0, 5'b00100, 1, 5, 1, 8});  // evicts a 0 -> {1,5,2}
    vecs.push_back('{1'b0, 5'b00001, 1, 5, 1, 8});  // evicts a 0, same class
    vecs.push_back('{1'b0, 5'b01000, 1, 4, 0, 8});  // evicts a 1 -> {1,4,2,1}
    // Tie: class 3 then class 1.
    vecs.push_back('{1'b1, 5'b01000, 3, 1, 1, 1});
    vecs.push_back('{1'b0, 5'b00010, 1, 1, 0, 2});

    // --- reset state -----------------------------------------------------
    repeat (2) @(posedge CLK);
    #1;
    check("rst.out_valid",  int'(bus.out_valid),  0);
    check("rst.out_class",  int'(bus.out_class),  0);
    check("rst.out_onehot", int'(bus.out_onehot), 0);
    check("rst.out_votes",  int'(bus.out_votes),  0);
    check("rst.out_conf",   int'(bus.out_conf),   0);
    check("rst.fill",       int'(fill),           0);
    check("rst.err_count",  int'(err_count),      0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst.in_ready", int'(bus.in_ready), 1);

    // --- table-driven stream ---------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      send_sample(vecs[i].dec);
      check_result($sformatf("vec%0d", i), vecs[i].cls, vecs[i].votes,
                   vecs[i].conf, vecs[i].fill);
    end

    // Result is consumed and nothing new arrives: out_valid falls.
    @(posedge CLK);
    #1;
    check("idle.out_valid", int'(bus.out_valid), 0);
    check("idle.fill",      int'(fill),          2);

    // --- invalid decisions -----------------------------------------------
    send_sample(5'b00000);
    check("inv0.out_valid", int'(bus.out_valid), 0);
    check("inv0.err_count", int'(err_count),     1);
    check("inv0.fill",      int'(fill),          2);
    send_sample(5'b00110);
    check("inv1.out_valid", int'(bus.out_valid), 0);
    check("inv1.err_count", int'(err_count),     2);
    check("inv1.fill",      int'(fill),          2);

    // Saturation of the 4-bit error counter at 15.
    for (int i = 0; i < 13; i++) send_sample(5'b11000);
    check("sat.err_count_at_max", int'(err_count), 15);
    for (int i = 0; i < 2; i++) send_sample(5'b11111);
    check("sat.err_count_held", int'(err_count), 15);
    check("sat.fill",           int'(fill),      2);
    check("sat.out_valid",      int'(bus.out_valid), 0);

    // --- backpressure ----------------------------------------------------
    // Window holds {0,1,0,1}; class 0 arrives with the host stalled.
    @(negedge CLK);
    bus.out_ready = 1'b0;
    send_sample(5'b00001);
    check_result("bp.held", 0, 1, 0, 3);
    @(negedge CLK);
    bus.in_valid    = 1'b1;
    bus.in_decision = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("bp.in_ready%0d", i), int'(bus.in_ready), 0);
      check_result($sformatf("bp.stable%0d", i), 0, 1, 0, 3);
    end
    @(negedge CLK);
    bus.out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", int'(bus.in_ready), 1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    check_result("bp.next", 1, 2, 0, 4);

    // --- clear -----------------------------------------------------------
    send_sample(5'b00010);
    check_result("pre_clear5", 1, 3, 1, 5);
    send_sample(5'b00010);
    check_result("pre_clear6", 1, 4, 1, 6);
    @(negedge CLK);
    clear           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_decision = 5'b10000;
    #1;
    check("clr.in_ready", int'(bus.in_ready), 0);
    @(posedge CLK);
    #1;
    check("clr.out_valid", int'(bus.out_valid), 0);
    check("clr.fill",      int'(fill),          0);
    check("clr.err_count", int'(err_count),     15);
    @(negedge CLK);
    clear = 1'b0;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    check_result("post_clear", 4, 1, 1, 1);
    check("post_clear.err_count", int'(err_count), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt_vote_filter.md
Name: dt_vote_filter

Overview:
- Downstream of the locked decision-tree classifier: consumes its 5-bit one-hot `decision` per feature frame.
- Smooths it over a sliding window of the last WIN valid decisions using per-class vote counters.
- Emits the majority class with a confidence flag over a valid/ready handshake to the wearable host interface.
- Rejects and counts non-one-hot decisions; a wrong KEY typically produces these.

Parameters:
- NUM_CLASSES, 5, width of the one-hot decision input.
- WIN, 8, window depth in samples; legal range 2..16.
- CNT_W, 5, vote/fill counter width; must satisfy 2^CNT_W > WIN.
- ERR_W, 16, width of the invalid-input counter.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- clear  in  1  synchronous window flush.
- in_valid  in  1  decision sample present.
- in_ready  out  1  filter can accept a sample.
- in_decision  in  NUM_CLASSES  one-hot class vector from the classifier.
- out_valid  out  1  smoothed result present.
- out_ready  in  1  consumer accepts the result.
- out_class  out  3  index of the winning class.
- out_onehot  out  NUM_CLASSES  one-hot form of out_class.
- out_votes  out  CNT_W  vote count of the winner.
- out_conf  out  1  strict majority: 2*out_votes > fill.
- fill  out  CNT_W  samples currently in the window (0..WIN).
- err_count  out  ERR_W  saturating count of rejected (non-one-hot) inputs.

Behaviour:
- Reset (RST=1 at an edge): out_valid=0, out_class=0, out_onehot=0, out_votes=0, out_conf=0, fill=0, err_count=0. All vote counters=0, ring write pointer=0, FSM=EMPTY.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready).
  - A sample is accepted when in_valid && in_ready.
  - out_valid holds, with all out_* stable, until out_ready is seen high.
- Sample classification: valid iff exactly one bit of in_decision is set. Covers 0 bits and 2 or more bits.
- Invalid accepted sample:
  - err_count increments, saturating at all-ones.
  - Window, counters, fill and outputs are unchanged; no output is produced.
- Valid accepted sample with class c:
  - Ring[wptr] <= c; wptr advances modulo WIN; count[c] increments.
  - If fill == WIN, the evicted class e = ring[wptr] has count[e] decremented in the same cycle. When e == c the count is unchanged.
  - fill increments, saturating at WIN.
- Output latency: exactly 1 cycle. The edge that accepts a valid sample loads out_* from the post-update counters and sets out_valid=1.
  - Argmax over the post-update counts; ties resolve to the lowest class index.
  - out_conf uses the post-update fill.
  - If out_valid was 1 and out_ready is 1 in the same cycle, the new result replaces the old one (back-to-back throughput 1/cycle).
- out_valid falls when out_ready=1 and no new valid sample is accepted that cycle.
- FSM: EMPTY (fill=0) -> FILLING (0<fill<WIN) -> FULL (fill=WIN).
  - The FSM gates eviction: only FULL evicts.
  - clear returns the FSM to EMPTY.
- clear:
  - Next edge: counters=0, fill=0, wptr=0, out_valid=0, FSM=EMPTY.
  - err_count is retained.
  - in_ready is forced low, so no sample is lost to the flush.
- RST has priority over clear. Both abort any held output; a result not yet taken is discarded.

Decomposition:
- Package dt_vote_pkg holds: NUM_CLASSES, the class index type (3-bit), the FSM state enum {EMPTY, FILLING, FULL}, and the onehot_to_index / is_onehot helper functions.
- One sub-module, dt_vote_argmax: combinational argmax with lowest-index tie break over NUM_CLASSES counts. Outputs the index and the winning count.

Test Plan:
- Reset, then 3 samples of class 2 (5'b00100) -> 3 results, each 1 cycle after accept; out_class=2, out_votes=1/2/3, fill=1/2/3, out_conf=1 throughout.
- WIN=8; feed classes 0,0,0,1,1,1,1,1 then 2 -> 8th result: class 1, votes 5, conf 1. 9th sample evicts one class 0 -> counts {2,5,1}, result class 1, votes 5, fill 8.
- Tie: classes 3,1 after reset -> 2nd result out_class=1, out_votes=1, out_conf=0 (2*1 not > 2).
- Invalid inputs 5'b00000 then 5'b00110 -> no out_valid, err_count=2, fill unchanged. Set err_count to near all-ones with repeated invalids -> holds at all-ones.
- Backpressure: out_ready=0 with result held, in_valid=1 -> in_ready=0, out_* stable for 5 cycles. Raise out_ready -> held result accepted, queued sample accepted the same cycle, new result next cycle.
- clear with fill=6 and out_valid=1 -> next cycle out_valid=0, fill=0, in_ready low during clear; then one class 4 sample -> out_class=4, votes 1, err_count preserved.
